lt2208_frame_capture: RTL and testbench
=======================================

Name: lt2208_frame_capture

Overview:
- Upstream stage of the FX2 spectrum path, in the LT2208 125 MHz clock domain.
- Registers and de-randomizes LT2208 samples and writes one frame of 2^ADDR_W samples into the write port of the 4096-word dual-port RAM.
- Signals frame_ready to the IFCLK-side reader, which streams the frame to EP6.
- Also reports per-frame peak magnitude and ADC overflow so the host can flag clipped frames.

Parameters:
- ADDR_W, 12, RAM address width; frame length = 2^ADDR_W samples.
- DATA_W, 16, sample width; fixed at 16 for the LT2208.
- SETTLE, 16, samples discarded after arm before capture starts, range 0..255.

Ports:
- clock  in  1  LT2208 sample clock (125 MHz, FPGA_CLK6IN); all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- ADC  in  16  raw LT2208 output bus, valid at posedge clock.
- OVF  in  1  LT2208 overflow flag, same timing as ADC.
- derand_en  in  1  1 = LT2208 output randomizer is on, so de-randomize.
- arm  in  1  single-cycle pulse, already synchronized to clock; requests a frame.
- release  in  1  single-cycle pulse, already synchronized; reader has finished the frame.
- ram_data  out  16  write data to the RAM data port.
- ram_wraddress  out  ADDR_W  RAM write address.
- ram_wren  out  1  RAM write enable.
- frame_ready  out  1  a complete frame is in RAM.
- busy  out  1  high in SETTLE or CAPTURE.
- peak_mag  out  15  max |sample| of the last frame, saturated.
- ovf_seen  out  1  OVF was high on at least one captured sample of the last frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Pipeline:
  - Stage 1 registers ADC and OVF.
  - Stage 2 de-randomizes the stage-1 data: if derand_en=1 and bit0=1, out = {~d[15:1], d[0]}; otherwise out = d. Stage 2 drives ram_data.
  - The pipeline runs in every state.
  - Latency: a sample on ADC at edge k appears on ram_data after edge k+2.
- Qualifier: a valid flag travels alongside the pipeline data, so ram_wren is asserted only for samples that entered stage 1 while the FSM was in CAPTURE.
- FSM states: IDLE, SETTLE, CAPTURE, READY.
  - IDLE: on arm go to SETTLE. Clear the settle counter, sample counter, peak_mag and ovf_seen. frame_ready=0.
  - SETTLE: count SETTLE clocks, then go to CAPTURE. With SETTLE=0, go from IDLE to CAPTURE directly.
  - CAPTURE: accept exactly 2^ADDR_W consecutive samples, one per clock.
  - After the last sample is accepted, go to READY. Keep ram_wren alive until the pipeline drains; the last write lands two clocks after leaving CAPTURE.
  - READY: assert frame_ready one clock after the last ram_wren. Hold frame_ready until release, then return to IDLE the next clock with frame_ready=0.
- Addressing:
  - ram_wraddress starts at 0 for each frame and increments by 1 after each write.
  - It wraps from 2^ADDR_W-1 to 0 without leaving a gap, and equals 0 again in READY.
- Peak magnitude (updated only on written samples; the sample is two's complement):
  - mag = |s|, with -32768 saturating to 32767.
  - peak_mag = max(peak_mag, mag).
- ovf_seen: ORed from the stage-2 OVF of written samples only.
- Simultaneous and out-of-state events:
  - arm while busy or in READY: ignored.
  - release outside READY: ignored.
  - arm and release in the same cycle in READY: release wins (go to IDLE); that arm is dropped.
  - peak_mag and ovf_seen stay stable from READY entry until the next arm.
- Reset mid-frame: immediate return to IDLE. ram_wren drops asynchronously with reset; the partial frame is abandoned and frame_ready stays 0.
- Width rules: all counters use ADDR_W or 8 bits with explicit wrap; there is no implicit truncation.

Test Plan:
- Reset then idle: hold ADC=16'h1234 and toggle nothing. Required: ram_wren never asserts; all outputs 0.
- De-randomize: derand_en=1, ADC=16'h0003 -> ram_data=16'hFFFD two clocks later. ADC=16'h0002 -> 16'h0002. With derand_en=0, 16'h0003 passes unchanged.
- Full frame with SETTLE=16 and ADC as a ramp 0,1,2,...: arm.
  - First ram_wren occurs 16+2 clocks after the SETTLE entry edge, at address 0.
  - Exactly 4096 writes, addresses 0..4095 contiguous, each data equal to address + offset.
  - frame_ready rises one clock after the write to 4095.
- Peak/overflow: a frame containing -32768 and 12000, with OVF pulsed on one captured sample. Required: peak_mag=32767 and ovf_seen=1. An OVF pulse during SETTLE alone gives ovf_seen=0.
- Handshake: arm during CAPTURE and arm in READY are both ignored. release in READY returns to IDLE. A following arm starts a new frame at address 0, and peak_mag is cleared.
- Async reset at address 2000 of a frame: ram_wren=0 and the FSM is in IDLE before the next edge. A subsequent arm captures a clean 4096-sample frame.

Source files
------------

// File: rtl/lt2208_frame_capture_if.sv
// Signal bundle between the LT2208 capture block and its surroundings:
// ADC bus in, RAM write port and frame handshake out.
interface lt2208_frame_capture_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] ADC;
    logic              OVF;
    logic              derand_en;
    logic              arm;
    logic              release_pulse;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_wraddress;
    logic              ram_wren;
    logic              frame_ready;
    logic              busy;
    logic [DATA_W-2:0] peak_mag;
    logic              ovf_seen;

    modport master (
        output ADC, OVF, derand_en, arm, release_pulse,
        input  ram_data, ram_wraddress, ram_wren, frame_ready, busy, peak_mag, ovf_seen
    );

    modport slave (
        input  ADC, OVF, derand_en, arm, release_pulse,
        output ram_data, ram_wraddress, ram_wren, frame_ready, busy, peak_mag, ovf_seen
    );
endinterface

// File: rtl/lt2208_frame_capture.sv
// Captures one frame of de-randomized LT2208 samples into the dual-port RAM
// write port, with per-frame peak magnitude and overflow reporting.
module lt2208_frame_capture #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int SETTLE = 16
) (
    input logic clock,
    input logic reset,
    lt2208_frame_capture_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_READY} state_t;

    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] LAST_SAMPLE = {ADDR_W{1'b1}};

    state_t              state_reg, state_next;
    logic [7:0]          settle_cnt_reg, settle_cnt_next;
    logic [ADDR_W-1:0]   sample_cnt_reg, sample_cnt_next;
    logic                clear_stats;
    logic                frame_ready_reg, frame_ready_next;

    logic [DATA_W-1:0]   s1_data_reg;
    logic                s1_ovf_reg;
    logic                s1_vld_reg;
    logic [DATA_W-1:0]   derand_word;
    logic [DATA_W-1:0]   neg_word;
    logic [DATA_W-2:0]   sample_mag;

    logic [DATA_W-1:0]   ram_data_reg;
    logic                ram_wren_reg;
    logic [ADDR_W-1:0]   ram_wraddress_reg;
    logic [DATA_W-2:0]   peak_mag_reg;
    logic                ovf_seen_reg;

    // Randomizer: every bit above bit 0 is XORed with bit 0.
    assign derand_word[0] = s1_data_reg[0];
    genvar gi;
    generate
        for (gi = 1; gi < DATA_W; gi++) begin : g_derand
            assign derand_word[gi] = s1_data_reg[gi] ^ (bus.derand_en & s1_data_reg[0]);
        end
    endgenerate

    // Magnitude is computed on the word entering stage 2 so the peak settles
    // together with the last RAM write.
    assign neg_word = ~derand_word + {{(DATA_W-1){1'b0}}, 1'b1};
    always_comb begin
        sample_mag = derand_word[DATA_W-2:0];
        if (derand_word[DATA_W-1]) begin
            if (derand_word[DATA_W-2:0] == '0)
                sample_mag = {(DATA_W-1){1'b1}};
            else
                sample_mag = neg_word[DATA_W-2:0];
        end
    end

    always_comb begin
        state_next       = state_reg;
        settle_cnt_next  = settle_cnt_reg;
        sample_cnt_next  = sample_cnt_reg;
        clear_stats      = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                settle_cnt_next = '0;
                sample_cnt_next = '0;
                if (bus.arm) begin
                    clear_stats = 1'b1;
                    state_next  = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST)
                    state_next = ST_CAPTURE;
                else
                    settle_cnt_next = settle_cnt_reg + 8'd1;
            end
            ST_CAPTURE: begin
                sample_cnt_next = sample_cnt_reg + ADDR_W'(1);
                if (sample_cnt_reg == LAST_SAMPLE)
                    state_next = ST_READY;
            end
            ST_READY: begin
                if (bus.release_pulse)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Ready only once the valid flag has left stage 1, i.e. the last write is on the bus.
        frame_ready_next = (state_reg == ST_READY) && !bus.release_pulse && !s1_vld_reg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            settle_cnt_reg    <= '0;
            sample_cnt_reg    <= '0;
            frame_ready_reg   <= 1'b0;
            s1_data_reg       <= '0;
            s1_ovf_reg        <= 1'b0;
            s1_vld_reg        <= 1'b0;
            ram_data_reg      <= '0;
            ram_wren_reg      <= 1'b0;
            ram_wraddress_reg <= '0;
            peak_mag_reg      <= '0;
            ovf_seen_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            settle_cnt_reg  <= settle_cnt_next;
            sample_cnt_reg  <= sample_cnt_next;
            frame_ready_reg <= frame_ready_next;

            s1_data_reg  <= bus.ADC;
            s1_ovf_reg   <= bus.OVF;
            s1_vld_reg   <= (state_reg == ST_CAPTURE);
            ram_data_reg <= derand_word;
            ram_wren_reg <= s1_vld_reg;

            if (clear_stats)
                ram_wraddress_reg <= '0;
            else if (ram_wren_reg)
                ram_wraddress_reg <= ram_wraddress_reg + ADDR_W'(1);

            if (clear_stats) begin
                peak_mag_reg <= '0;
                ovf_seen_reg <= 1'b0;
            end else if (s1_vld_reg) begin
                if (sample_mag > peak_mag_reg)
                    peak_mag_reg <= sample_mag;
                ovf_seen_reg <= ovf_seen_reg | s1_ovf_reg;
            end
        end
    end

    assign bus.ram_data      = ram_data_reg;
    assign bus.ram_wren      = ram_wren_reg;
    assign bus.ram_wraddress = ram_wraddress_reg;
    assign bus.frame_ready   = frame_ready_reg;
    assign bus.busy          = (state_reg == ST_SETTLE) || (state_reg == ST_CAPTURE);
    assign bus.peak_mag      = peak_mag_reg;
    assign bus.ovf_seen      = ovf_seen_reg;
endmodule

// File: tb/tb_lt2208_frame_capture.sv
// Randomized bench for lt2208_frame_capture against a frame-level reference:
// expected RAM contents, peak and overflow come from the driven sample log.
module tb_lt2208_frame_capture;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int SETTLE = 16;
    localparam int FRAME  = 1 << ADDR_W;

    logic clock = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    lt2208_frame_capture_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lt2208_frame_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE(SETTLE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [15:0] ref_derand(input logic [15:0] d, input bit en);
        if (en && d[0]) return {~d[15:1], d[0]};
        return d;
    endfunction

    function automatic int ref_mag(input logic [15:0] d);
        int s;
        s = $signed(d);
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return s;
    endfunction

    task automatic derand_probe(input bit en, input logic [15:0] d);
        @(posedge clock); #1;
        bus.derand_en = en;
        bus.ADC       = d;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("derand", bus.ram_data, ref_derand(d, en));
        $display("[TB] derand en=%0d in=%04h out=%04h", en, d, bus.ram_data);
    endtask

    task automatic pulse(input bit a, input bit r);
        @(posedge clock); #1;
        bus.arm           = a;
        bus.release_pulse = r;
        @(posedge clock); #1;
        bus.arm           = 1'b0;
        bus.release_pulse = 1'b0;
        @(negedge clock);
    endtask

    // One frame: arm at k=0, drive one sample per cycle, log every RAM write.
    // Sample k is taken at the (k+1)th edge after the arm was driven, so the
    // captured window is samples SETTLE+1 .. SETTLE+FRAME.
    task automatic run_frame(input int id, input bit ramp, input bit dr_en, input int ovf_at,
                             input int arm_at, input int rel_at, input int abort_addr, input bit inject);
        logic [15:0] smp[$];
        bit          ovfq[$];
        logic [15:0] v;
        int first_wr = -1, last_wr = -1, ready_at = -1, nwr = 0, addr_err = 0, data_err = 0;
        int exp_peak = 0, m;
        bit exp_ovf = 1'b0;
        bus.derand_en = dr_en;
        for (int k = 0; k < SETTLE + FRAME + 40; k++) begin
            @(posedge clock); #1;
            if (ramp)                          v = 16'(k);
            else if (inject && k == SETTLE+101)  v = 16'h8000;
            else if (inject && k == SETTLE+3001) v = 16'd12000;
            else if (inject)                   v = 16'($urandom_range(0, 4000) - 2000);
            else                               v = 16'($urandom);
            smp.push_back(v);
            ovfq.push_back(k == ovf_at);
            bus.ADC           = v;
            bus.OVF           = (k == ovf_at);
            bus.arm           = (k == 0) || (k == arm_at);
            bus.release_pulse = (k == rel_at);
            @(negedge clock);
            if (k == 1) begin
                check("peak_clear_on_arm", bus.peak_mag, 0);
                check("ovf_clear_on_arm", bus.ovf_seen, 0);
                check("busy_after_arm", bus.busy, 1);
            end
            if (bus.ram_wren) begin
                int idx = SETTLE + 1 + nwr;
                if (first_wr < 0) first_wr = k;
                last_wr = k;
                if (int'(bus.ram_wraddress) != nwr % FRAME) addr_err++;
                if (idx >= smp.size() || bus.ram_data != ref_derand(smp[idx], dr_en)) data_err++;
                if (ramp && bus.ram_data != 16'(int'(bus.ram_wraddress) + SETTLE + 1)) data_err++;
                nwr++;
                if (abort_addr >= 0 && int'(bus.ram_wraddress) == abort_addr) begin
                    reset = 1'b1;
                    #1;
                    check("abort_wren", bus.ram_wren, 0);
                    check("abort_busy", bus.busy, 0);
                    check("abort_ready", bus.frame_ready, 0);
                    check("abort_addr", bus.ram_wraddress, 0);
                    check("abort_prefix_addr_err", addr_err, 0);
                    check("abort_prefix_data_err", data_err, 0);
                    #1;
                    reset = 1'b0;
                    bus.arm = 1'b0; bus.release_pulse = 1'b0; bus.OVF = 1'b0;
                    $display("[TB] frame %0d: reset at address %0d after %0d writes", id, abort_addr, nwr);
                    return;
                end
            end
            if (bus.frame_ready) begin
                ready_at = k;
                break;
            end
        end
        bus.arm = 1'b0; bus.release_pulse = 1'b0; bus.OVF = 1'b0;

        for (int i = SETTLE + 1; i <= SETTLE + FRAME && i < smp.size(); i++) begin
            m = ref_mag(ref_derand(smp[i], dr_en));
            if (m > exp_peak) exp_peak = m;
            exp_ovf |= ovfq[i];
        end

        check("first_wren_cycle", first_wr, SETTLE + 3);
        check("write_count", nwr, FRAME);
        check("addr_errors", addr_err, 0);
        check("data_errors", data_err, 0);
        check("ready_cycle", ready_at, SETTLE + FRAME + 3);
        check("ready_after_last_write", ready_at, last_wr + 1);
        check("peak_mag", bus.peak_mag, exp_peak);
        check("ovf_seen", bus.ovf_seen, int'(exp_ovf));
        check("ready_addr", bus.ram_wraddress, 0);
        check("ready_busy", bus.busy, 0);
        check("ready_wren", bus.ram_wren, 0);
        $display("[TB] frame %0d: writes=%0d first=%0d ready=%0d peak=%0d ovf=%0d",
                 id, nwr, first_wr, ready_at, bus.peak_mag, bus.ovf_seen);
    endtask

    initial begin
        int wren_cnt;
        logic [14:0] saved_peak;
        logic [15:0] d;
        bit en;

        reset = 1'b1;
        bus.ADC = 16'h1234; bus.OVF = 1'b0; bus.derand_en = 1'b0;
        bus.arm = 1'b0; bus.release_pulse = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_wren", bus.ram_wren, 0);
        check("rst_ready", bus.frame_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_peak", bus.peak_mag, 0);
        check("rst_ovf", bus.ovf_seen, 0);
        check("rst_data", bus.ram_data, 0);
        check("rst_addr", bus.ram_wraddress, 0);
        reset = 1'b0;

        wren_cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.ram_wren) wren_cnt++;
        end
        check("idle_wren_count", wren_cnt, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_ready", bus.frame_ready, 0);
        check("idle_addr", bus.ram_wraddress, 0);
        check("idle_peak", bus.peak_mag, 0);
        $display("[TB] idle: %0d cycles, wren seen %0d", 40, wren_cnt);

        derand_probe(1'b1, 16'h0003);
        check("derand_fffd", bus.ram_data, 16'hFFFD);
        derand_probe(1'b1, 16'h0002);
        check("derand_0002", bus.ram_data, 16'h0002);
        derand_probe(1'b0, 16'h0003);
        check("derand_off", bus.ram_data, 16'h0003);
        for (int i = 0; i < 16; i++) begin
            d  = 16'($urandom);
            en = 1'($urandom);
            derand_probe(en, d);
        end

        // Ramp frame; arm and release during CAPTURE must be ignored.
        run_frame(1, 1'b1, 1'b0, -1, SETTLE + 200, SETTLE + 300, -1, 1'b0);
        pulse(1'b1, 1'b0);
        repeat (3) @(negedge clock);
        check("arm_in_ready_ready", bus.frame_ready, 1);
        check("arm_in_ready_busy", bus.busy, 0);
        check("arm_in_ready_wren", bus.ram_wren, 0);
        saved_peak = bus.peak_mag;
        pulse(1'b0, 1'b1);
        check("release_ready", bus.frame_ready, 0);
        check("release_busy", bus.busy, 0);
        check("release_peak_stable", bus.peak_mag, saved_peak);
        $display("[TB] release after frame 1");

        // Full-scale negative and OVF on one captured sample.
        run_frame(2, 1'b0, 1'b1, SETTLE + 501, -1, -1, -1, 1'b1);
        check("peak_saturated", bus.peak_mag, 32767);
        check("ovf_captured", bus.ovf_seen, 1);
        pulse(1'b1, 1'b1);
        check("arm_rel_ready", bus.frame_ready, 0);
        check("arm_rel_busy", bus.busy, 0);
        repeat (5) @(negedge clock);
        check("arm_rel_dropped_busy", bus.busy, 0);
        check("arm_rel_dropped_wren", bus.ram_wren, 0);
        $display("[TB] arm+release in READY");

        // OVF only during SETTLE.
        run_frame(3, 1'b0, 1'b0, 3, -1, -1, -1, 1'b0);
        check("ovf_settle_only", bus.ovf_seen, 0);
        pulse(1'b0, 1'b1);

        run_frame(4, 1'b0, 1'b0, -1, -1, -1, 2000, 1'b0);
        repeat (3) @(negedge clock);
        check("post_abort_ready", bus.frame_ready, 0);
        check("post_abort_wren", bus.ram_wren, 0);

        // Clean frame after the abort; OVF on the very last captured sample.
        run_frame(5, 1'b0, 1'($urandom), SETTLE + FRAME, -1, 5, -1, 1'b0);
        check("ovf_last_sample", bus.ovf_seen, 1);
        pulse(1'b0, 1'b1);
        check("final_ready", bus.frame_ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
